sum_uart_tx: RTL and testbench
==============================

SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001 SHALL have parameter WIDTH, default 4, the adder operand width (sum is WIDTH+1 bits).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 234, the clock cycles per UART bit (27 MHz / 115200 baud).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port sum_i  input  WIDTH+1  unsigned adder result to report.
REQ-006 SHALL have port valid_i  input  1  sum_i holds a result to send.
REQ-007 SHALL have port ready_o  output  1  block can accept a result.
REQ-008 SHALL have port tx_o  output  1  UART serial line; idle high.
REQ-009 SHALL have port busy_o  output  1  frame in progress; always the inverse of ready_o.

Function
REQ-010 SHALL accept a result on a clk edge where valid_i and ready_o are both high, capturing sum_i into an internal register.
REQ-011 SHALL assert ready_o only in IDLE; while busy, valid_i and sum_i are ignored and the captured value stays stable.
REQ-012 SHALL send one frame per accepted result: NDIG = ceil((WIDTH+1)/4) hex digits, most significant first, then 0x0D, then 0x0A.
REQ-013 SHALL encode digits 0-9 as 0x30-0x39 and A-F as 0x41-0x46 (uppercase), zero-padding the top digit.
REQ-014 SHALL send each byte as a start bit (0), 8 data bits LSB first, and a stop bit (1); each bit is held exactly CLKS_PER_BIT cycles.
REQ-015 SHALL use states IDLE -> START -> DATA (8 bits) -> STOP; STOP goes to START for the next byte, or to IDLE after the LF byte.
REQ-016 SHALL drive tx_o low starting the cycle after acceptance; there are no idle bits between bytes within a frame.
REQ-017 SHALL make a frame exactly (NDIG+2)*10*CLKS_PER_BIT cycles; ready_o rises the cycle after the final stop bit ends.
REQ-018 SHALL, with valid_i held high continuously, give exactly one IDLE cycle (tx_o high) between consecutive frames.
REQ-019 SHALL register tx_o so it is glitch-free; its bit counter wraps from CLKS_PER_BIT-1 to 0.

Reset
REQ-020 SHALL, on rst, force the state to IDLE, tx_o=1, ready_o=1, busy_o=0, and clear all counters and the captured sum on the next edge.
REQ-021 SHALL, if reset arrives mid-frame, abort the frame, drive tx_o high from the next cycle, and never resume the aborted frame.
REQ-022 SHALL give rst priority over a simultaneous valid_i; no result is accepted on that edge.

Structure
REQ-023 SHALL keep ASCII constants (0x30, 0x41, 0x0D, 0x0A), state encodings and the default CLKS_PER_BIT in shared package sum_uart_pkg.
REQ-024 SHALL place the byte serializer (START/DATA/STOP, bit timer, byte valid/ready) in sub-module uart_tx_byte; the top level holds digit sequencing and the handshake.

Verification (all scenarios use WIDTH=4 and CLKS_PER_BIT=4, giving 160-cycle frames)
REQ-025 SHALL check: reset held 3 cycles -> tx_o=1, ready_o=1, busy_o=0 throughout and after release.
REQ-026 SHALL check: sum_i=5'h1F accepted -> line decodes 0x31, 0x46, 0x0D, 0x0A; tx_o low the cycle after acceptance; ready_o high 161 cycles after acceptance.
REQ-027 SHALL check: sum_i=5'h00 -> 0x30, 0x30, 0x0D, 0x0A; and sum_i=5'h10 -> 0x31, 0x30, 0x0D, 0x0A.
REQ-028 SHALL check: valid_i held high with sum_i changing to 5'h07 during a 5'h0A frame -> the frame still decodes "0A"; the next frame is "07" after exactly one idle cycle.
REQ-029 SHALL check: rst pulsed during DATA of the second byte -> tx_o=1 the next cycle with no further falling edges; ready_o=1; a new 5'h15 frame then decodes "15\r\n".
REQ-030 SHALL check: the whole exhaustive sweep of a,b in 0..15 fed through the adder -> each decoded frame equals the hex of a+b.

Source files
------------

// File: rtl/sum_uart_pkg.sv
// Shared constants, state encodings and the hex-to-ASCII helper
// for the sum-to-UART reporter.
package sum_uart_pkg;

   localparam int DEF_CLKS_PER_BIT = 234;

   localparam logic [7:0] ASCII_ZERO = 8'h30;
   localparam logic [7:0] ASCII_A    = 8'h41;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_LF   = 8'h0A;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_t;

   typedef enum logic {
      SEQ_IDLE = 1'b0,
      SEQ_BUSY = 1'b1
   } seq_state_t;

   function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
      if (nib < 4'd10) return ASCII_ZERO + {4'h0, nib};
      else             return ASCII_A + {4'h0, nib - 4'd10};
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer. A new byte offered during the last stop-bit cycle
// starts immediately, so bytes within a frame are back to back.
//
// state    | meaning
// ST_IDLE  | line high, waiting for a byte
// ST_START | start bit (0)
// ST_DATA  | 8 data bits, LSB first
// ST_STOP  | stop bit (1); may chain into the next start bit
module uart_tx_byte
   import sum_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       valid,
   output logic       ready,
   output logic       tx
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t     state;
   logic [CW-1:0] clk_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (clk_cnt == LAST);
   assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         tx      <= 1'b1;
         clk_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         if ((state == ST_IDLE) || bit_end) clk_cnt <= '0;
         else                               clk_cnt <= clk_cnt + CW'(1);

         case (state)
            ST_IDLE: begin
               if (valid) begin
                  shreg <= data;
                  tx    <= 1'b0;
                  state <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  tx      <= shreg[0];
                  shreg   <= {1'b0, shreg[7:1]};
                  bit_idx <= '0;
                  state   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= ST_STOP;
                  end else begin
                     tx      <= shreg[0];
                     shreg   <= {1'b0, shreg[7:1]};
                     bit_idx <= bit_idx + 3'd1;
                  end
               end
            end
            ST_STOP: begin
               if (bit_end) begin
                  if (valid) begin
                     shreg <= data;
                     tx    <= 1'b0;
                     state <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sum_uart_tx.sv
// Reports an adder result on a UART line as uppercase hex followed by CR LF.
//
// state    | meaning
// SEQ_IDLE | ready for a result; serializer idle
// SEQ_BUSY | frame in progress, feeding digits then CR, LF
module sum_uart_tx
   import sum_uart_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [WIDTH:0] sum_i,
   input  logic           valid_i,
   output logic           ready_o,
   output logic           tx_o,
   output logic           busy_o
);

   localparam int NDIG   = (WIDTH + 4) / 4;
   localparam int NBYTES = NDIG + 2;
   localparam int PW     = 4 * NDIG;
   localparam int IW     = $clog2(NBYTES + 1);

   seq_state_t     seq_state;
   logic [WIDTH:0] sum_q;
   logic [IW-1:0]  byte_idx;
   logic           byte_valid;
   logic           byte_ready;
   logic [7:0]     byte_data;

   function automatic logic [7:0] frame_char(input logic [WIDTH:0] s, input logic [IW-1:0] idx);
      logic [PW-1:0] padded;
      padded = PW'(s);
      if (idx < IW'(NDIG))       return hex_ascii(padded[PW - 4 - 4 * int'(idx) +: 4]);
      else if (idx == IW'(NDIG)) return ASCII_CR;
      else                       return ASCII_LF;
   endfunction

   // In idle the first digit comes straight from sum_i so the start bit
   // goes out on the acceptance edge itself.
   always_comb begin
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      if (seq_state == SEQ_IDLE) begin
         byte_valid = valid_i;
         byte_data  = frame_char(sum_i, '0);
      end else begin
         byte_valid = (byte_idx < IW'(NBYTES));
         byte_data  = frame_char(sum_q, byte_idx);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         seq_state <= SEQ_IDLE;
         sum_q     <= '0;
         byte_idx  <= '0;
      end else begin
         case (seq_state)
            SEQ_IDLE: begin
               if (valid_i) begin
                  sum_q     <= sum_i;
                  byte_idx  <= IW'(1);
                  seq_state <= SEQ_BUSY;
               end
            end
            SEQ_BUSY: begin
               if (byte_ready) begin
                  if (byte_valid) begin
                     byte_idx <= byte_idx + IW'(1);
                  end else begin
                     byte_idx  <= '0;
                     seq_state <= SEQ_IDLE;
                  end
               end
            end
            default: seq_state <= SEQ_IDLE;
         endcase
      end
   end

   assign ready_o = (seq_state == SEQ_IDLE);
   assign busy_o  = ~ready_o;

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk  (clk),
      .rst  (rst),
      .data (byte_data),
      .valid(byte_valid),
      .ready(byte_ready),
      .tx   (tx_o)
   );

endmodule

// File: tb/tb_sum_uart_tx.sv
// Directed bench for sum_uart_tx: decodes the serial line and checks frames,
// latency, back-to-back spacing and mid-frame reset.
module tb_sum_uart_tx;

   localparam int WIDTH = 4;
   localparam int CPB   = 4;
   localparam int FRAME = 160;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [WIDTH:0] sum_i = '0;
   logic           valid_i = 1'b0;
   logic           ready_o, tx_o, busy_o;

   int n_cmp = 0;
   int n_err = 0;
   int pc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) pc <= pc + 1;

   sum_uart_tx #(
      .WIDTH(WIDTH),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .sum_i  (sum_i),
      .valid_i(valid_i),
      .ready_o(ready_o),
      .tx_o   (tx_o),
      .busy_o (busy_o)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] hexc(input int n);
      return (n < 10) ? 8'(48 + n) : 8'(55 + n);
   endfunction

   // Caller must be at a negedge; the current line value is examined first.
   task automatic recv_byte(output logic [7:0] b, output int start_pc);
      int g;
      g = 0;
      b = 8'h00;
      while (tx_o !== 1'b0 && g < 4 * FRAME) begin
         @(negedge clk);
         g++;
      end
      start_pc = pc;
      chk("start_found", {31'b0, tx_o}, 32'd0);
      if (tx_o === 1'b0) begin
         repeat (CPB / 2) @(negedge clk);
         for (int j = 0; j < 8; j++) begin
            repeat (CPB) @(negedge clk);
            b[j] = tx_o;
         end
         repeat (CPB) @(negedge clk);
         chk("stop_bit", {31'b0, tx_o}, 32'd1);
      end
   endtask

   task automatic recv_frame(output logic [31:0] f, output int first_pc);
      logic [7:0] b;
      int sp;
      f = '0;
      first_pc = 0;
      for (int k = 0; k < 4; k++) begin
         recv_byte(b, sp);
         if (k == 0) first_pc = sp;
         f = {f[23:0], b};
      end
   endtask

   task automatic wait_ready(output int at_pc);
      int g;
      g = 0;
      while (ready_o !== 1'b1 && g < 4 * FRAME) begin
         @(negedge clk);
         g++;
      end
      at_pc = pc;
   endtask

   // lat is measured from the cycle in which valid_i and ready_o were both high.
   task automatic send_frame(input logic [WIDTH:0] s, output logic [31:0] f, output int lat);
      int acc_cycle, sp, rp;
      @(negedge clk);
      sum_i   = s;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i   = 1'b0;
      acc_cycle = pc - 1;
      chk("tx_low_after_accept", {31'b0, tx_o}, 32'd0);
      recv_frame(f, sp);
      wait_ready(rp);
      lat = rp - acc_cycle;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [31:0] f, f2;
      int lat, s1, s2, rp, lows, g, s, acc;

      // Reset held for three edges.
      rst = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_tx", {31'b0, tx_o}, 32'd1);
         chk("rst_ready", {31'b0, ready_o}, 32'd1);
         chk("rst_busy", {31'b0, busy_o}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_tx", {31'b0, tx_o}, 32'd1);
      chk("post_rst_ready", {31'b0, ready_o}, 32'd1);
      chk("post_rst_busy", {31'b0, busy_o}, 32'd0);

      // 0x1F -> "1F\r\n", ready back 161 cycles after acceptance.
      send_frame(5'h1F, f, lat);
      chk("frame_1f", f, 32'h31460D0A);
      chk("lat_1f", lat, 32'd161);
      chk("busy_inv", {31'b0, busy_o}, 32'd0);

      send_frame(5'h00, f, lat);
      chk("frame_00", f, 32'h30300D0A);
      send_frame(5'h10, f, lat);
      chk("frame_10", f, 32'h31300D0A);

      // valid_i held high; sum_i changes while busy.
      @(negedge clk);
      sum_i   = 5'h0A;
      valid_i = 1'b1;
      @(negedge clk);
      sum_i = 5'h07;
      chk("busy_during_frame", {31'b0, busy_o}, 32'd1);
      recv_frame(f, s1);
      chk("frame_0a_held", f, 32'h30410D0A);
      g = 0;
      while (tx_o !== 1'b0 && g < 4 * FRAME) begin
         @(negedge clk);
         g++;
      end
      s2 = pc;
      valid_i = 1'b0;
      chk("idle_gap", s2 - s1, FRAME + 1);
      recv_frame(f2, g);
      chk("frame_07_next", f2, 32'h30370D0A);
      wait_ready(rp);

      // Reset in the middle of the second byte's data bits.
      @(negedge clk);
      sum_i   = 5'h0C;
      valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      acc = pc;
      repeat (50) @(negedge clk);
      chk("mid_frame_busy", {31'b0, busy_o}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_tx", {31'b0, tx_o}, 32'd1);
      chk("abort_ready", {31'b0, ready_o}, 32'd1);
      chk("abort_busy", {31'b0, busy_o}, 32'd0);
      rst  = 1'b0;
      lows = 0;
      repeat (200) begin
         @(negedge clk);
         if (tx_o !== 1'b1) lows++;
      end
      chk("no_resume", lows, 32'd0);
      chk("ready_after_abort", {31'b0, ready_o}, 32'd1);
      send_frame(5'h15, f, lat);
      chk("frame_15", f, 32'h31350D0A);
      chk("lat_15", lat, 32'd161);

      // Exhaustive adder sweep.
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            s = a + b;
            send_frame(5'(s), f, lat);
            chk($sformatf("sweep_%0d_%0d", a, b), f,
                {hexc(s / 16), hexc(s % 16), 8'h0D, 8'h0A});
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
